// File: rtl/port_uart_pkg.sv
// Shared state encoding and port bit positions for the port-mapped UART transmitter.
package port_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam int CTRL_TOG = 0;
  localparam int CTRL_CLR = 1;
  localparam int CTRL_EN  = 7;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;
  localparam int STAT_ECHO  = 4;

endpackage

// File: rtl/port_fifo.sv
// Small synchronous FIFO with push, pop and flush; flush wins over both.
module port_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [DW-1:0]          din,
  output logic [DW-1:0]          dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO only succeeds when a pop frees a slot on the same edge.
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !flush && !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/port_uart_tx.sv
// CPU-port driven 8N1 UART transmitter: TOG edges queue bytes, CLR rising edge flushes,
// EN gates the start of new frames. Status is decoded from registered state only.
module port_uart_tx
  import port_uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] out_p0,
  input  logic [7:0] out_p1,
  output logic [7:0] in_p0,
  output logic [7:0] in_p1,
  output logic       tx
);

  localparam int BW = $clog2(CLK_DIV);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);

  tx_state_e     state, state_d;
  logic [BW-1:0] bcnt, bcnt_d;
  logic [2:0]    bidx, bidx_d;
  logic [7:0]    sh, sh_d;
  logic          tx_d;
  logic          tog_q, clr_q, primed, ovf;
  logic          en, push_req, flush, pop;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          unused_ctrl;

  assign en          = out_p1[CTRL_EN];
  assign push_req    = primed && (out_p1[CTRL_TOG] != tog_q);
  assign flush       = primed && out_p1[CTRL_CLR] && !clr_q;
  assign unused_ctrl = ^out_p1[6:2];

  port_fifo #(
    .DEPTH(FIFO_DEPTH),
    .DW   (8)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push_req),
    .pop  (pop),
    .flush(flush),
    .din  (out_p0),
    .dout (fifo_dout),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // The first edge after reset only captures TOG/CLR so stale levels are not taken as edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tog_q  <= 1'b0;
      clr_q  <= 1'b0;
      primed <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      tog_q  <= out_p1[CTRL_TOG];
      clr_q  <= out_p1[CTRL_CLR];
      primed <= 1'b1;
      if (flush)                                ovf <= 1'b0;
      else if (push_req && fifo_full && !pop)   ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      bcnt  <= '0;
      bidx  <= '0;
      sh    <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_d;
      bcnt  <= bcnt_d;
      bidx  <= bidx_d;
      sh    <= sh_d;
      tx    <= tx_d;
    end
  end

  always_comb begin
    state_d = state;
    bcnt_d  = (bcnt == '0) ? bcnt : bcnt - 1'b1;
    bidx_d  = bidx;
    sh_d    = sh;
    tx_d    = tx;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        tx_d = 1'b1;
        if (en && !fifo_empty) begin
          pop     = 1'b1;
          sh_d    = fifo_dout;
          tx_d    = 1'b0;
          bcnt_d  = BAUD_MAX;
          state_d = START;
        end
      end
      START: begin
        if (bcnt == '0) begin
          tx_d    = sh[0];
          bidx_d  = '0;
          bcnt_d  = BAUD_MAX;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bcnt == '0) begin
          bcnt_d = BAUD_MAX;
          if (bidx == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            sh_d   = {1'b0, sh[7:1]};
            tx_d   = sh[1];
            bidx_d = bidx + 1'b1;
          end
        end
      end
      STOP: begin
        // Chaining straight into the next START keeps back-to-back frames gap-free.
        if (bcnt == '0) begin
          if (en && !fifo_empty) begin
            pop     = 1'b1;
            sh_d    = fifo_dout;
            tx_d    = 1'b0;
            bcnt_d  = BAUD_MAX;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_p0 = 8'(fifo_count);

  always_comb begin
    in_p1             = '0;
    in_p1[STAT_FULL]  = fifo_full;
    in_p1[STAT_EMPTY] = fifo_empty;
    in_p1[STAT_BUSY]  = (state != IDLE);
    in_p1[STAT_OVF]   = ovf;
    in_p1[STAT_ECHO]  = tog_q;
  end

endmodule

// File: tb/tb_port_uart_tx.sv
// Directed bench for port_uart_tx: queued bytes are scoreboarded and compared against
// the sampled tx waveform of each frame, plus status/occupancy checks at key points.
module tb_port_uart_tx;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME      = 10 * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] out_p0;
  logic [7:0] out_p1;
  logic [7:0] in_p0;
  logic [7:0] in_p1;
  logic       tx;

  int         assert_count = 0;
  int         fail_count   = 0;
  logic [7:0] sb [$];
  logic       tog;
  logic       en;
  logic       clr;

  port_uart_tx #(
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .out_p0(out_p0),
    .out_p1(out_p1),
    .in_p0 (in_p0),
    .in_p1 (in_p1),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ctrl();
    out_p1 = {en, 5'b00000, clr, tog};
  endtask

  // Presents a byte with a TOG change; the caller supplies the edge.
  task automatic apply_stimulus(input logic [7:0] data, input bit accepted);
    out_p0 = data;
    tog    = ~tog;
    drive_ctrl();
    if (accepted) sb.push_back(data);
  endtask

  function automatic logic [7:0] exp_status(input logic full, input logic empty,
                                            input logic busy, input logic ovf);
    return {3'b000, tog, ovf, busy, empty, full};
  endfunction

  // Starts on the first start-bit sample and leaves the bench one cycle past the stop bit.
  task automatic check_frame(input string tag, input int inject_at, input logic [7:0] inject_data);
    logic [FRAME-1:0] obs_line;
    logic [FRAME-1:0] exp_line;
    logic [FRAME-1:0] obs_busy;
    logic [7:0]       exp_byte;
    logic [9:0]       bits;
    check_output({tag, "_queued"}, 64'(sb.size() > 0), 64'd1);
    exp_byte = (sb.size() > 0) ? sb.pop_front() : 8'h00;
    bits     = {1'b1, exp_byte, 1'b0};
    for (int i = 0; i < FRAME; i++) begin
      obs_line[i] = tx;
      obs_busy[i] = in_p1[2];
      exp_line[i] = bits[i / CLK_DIV];
      if (i == inject_at) apply_stimulus(inject_data, 1'b1);
      tick();
    end
    check_output({tag, "_line"}, 64'(obs_line), 64'(exp_line));
    check_output({tag, "_busy"}, 64'(obs_busy), 64'({FRAME{1'b1}}));
  endtask

  initial begin
    int lows;
    reset  = 1'b1;
    out_p0 = 8'h00;
    tog    = 1'b1;
    en     = 1'b1;
    clr    = 1'b0;
    drive_ctrl();
    #1 reset = 1'b0;
    #1;
    check_output("rst_tx", 64'(tx), 64'd1);
    check_output("rst_in_p0", 64'(in_p0), 64'h00);
    check_output("rst_in_p1", 64'(in_p1), 64'h02);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_output("prime_in_p0", 64'(in_p0), 64'h00);
    check_output("prime_in_p1", 64'(in_p1), 64'h12);
    tick();
    check_output("prime_no_push", 64'(in_p0), 64'h00);

    $display("[TB] single frame");
    apply_stimulus(8'hA5, 1'b1);
    tick();
    check_output("a5_tx_before", 64'(tx), 64'd1);
    check_output("a5_count", 64'(in_p0), 64'd1);
    check_output("a5_status", 64'(in_p1), 64'(exp_status(1'b0, 1'b0, 1'b0, 1'b0)));
    tick();
    check_frame("a5", -1, 8'h00);
    check_output("a5_done_status", 64'(in_p1), 64'(exp_status(1'b0, 1'b1, 1'b0, 1'b0)));
    check_output("a5_done_tx", 64'(tx), 64'd1);

    $display("[TB] overflow with EN low, then burst");
    en = 1'b0;
    drive_ctrl();
    tick();
    for (int b = 1; b <= 5; b++) begin
      apply_stimulus(8'(b), b <= FIFO_DEPTH);
      tick();
    end
    check_output("ovf_count", 64'(in_p0), 64'd4);
    check_output("ovf_status", 64'(in_p1), 64'(exp_status(1'b1, 1'b0, 1'b0, 1'b1)));
    repeat (8) tick();
    check_output("en_low_tx", 64'(tx), 64'd1);
    en = 1'b1;
    drive_ctrl();
    tick();
    check_output("burst_count", 64'(in_p0), 64'd3);
    for (int f = 0; f < 4; f++) check_frame($sformatf("burst%0d", f), -1, 8'h00);
    check_output("burst_done_status", 64'(in_p1), 64'(exp_status(1'b0, 1'b1, 1'b0, 1'b1)));

    $display("[TB] flush");
    en = 1'b0;
    drive_ctrl();
    tick();
    apply_stimulus(8'h11, 1'b1);
    tick();
    apply_stimulus(8'h22, 1'b1);
    tick();
    check_output("pre_flush_count", 64'(in_p0), 64'd2);
    clr = 1'b1;
    apply_stimulus(8'h33, 1'b0);
    tick();
    sb.delete();
    check_output("flush_count", 64'(in_p0), 64'd0);
    check_output("flush_status", 64'(in_p1), 64'(exp_status(1'b0, 1'b1, 1'b0, 1'b0)));
    clr = 1'b0;
    drive_ctrl();
    tick();
    en = 1'b1;
    drive_ctrl();
    lows = 0;
    for (int i = 0; i < 12; i++) begin
      if (tx === 1'b0) lows++;
      tick();
    end
    check_output("flush_no_tx", 64'(lows), 64'd0);

    $display("[TB] push while full on pop edges");
    en = 1'b0;
    drive_ctrl();
    tick();
    for (int b = 0; b < 4; b++) begin
      apply_stimulus(8'hB0 + 8'(b), 1'b1);
      tick();
    end
    check_output("full_status", 64'(in_p1), 64'(exp_status(1'b1, 1'b0, 1'b0, 1'b0)));
    en = 1'b1;
    apply_stimulus(8'hB4, 1'b1);
    tick();
    check_output("idle_pop_push_count", 64'(in_p0), 64'd4);
    check_frame("full0", FRAME - 1, 8'hB5);
    check_output("stop_pop_push_count", 64'(in_p0), 64'd4);
    check_output("stop_pop_push_status", 64'(in_p1), 64'(exp_status(1'b1, 1'b0, 1'b1, 1'b0)));
    for (int f = 1; f <= 5; f++) check_frame($sformatf("full%0d", f), -1, 8'h00);
    check_output("full_done_status", 64'(in_p1), 64'(exp_status(1'b0, 1'b1, 1'b0, 1'b0)));

    $display("[TB] reset mid-frame");
    apply_stimulus(8'hC3, 1'b1);
    tick();
    apply_stimulus(8'h3C, 1'b1);
    tick();
    repeat (13) tick();
    check_output("mid_data_tx", 64'(tx), 64'd0);
    #2 reset = 1'b0;
    #1;
    sb.delete();
    check_output("async_rst_tx", 64'(tx), 64'd1);
    check_output("async_rst_in_p0", 64'(in_p0), 64'h00);
    check_output("async_rst_in_p1", 64'(in_p1), 64'h02);
    tick();
    reset = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx === 1'b0) lows++;
    end
    check_output("post_rst_no_tx", 64'(lows), 64'd0);
    check_output("post_rst_status", 64'(in_p1), 64'(exp_status(1'b0, 1'b1, 1'b0, 1'b0)));

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
